// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronises raw sources, detects rising edges into
// pending bits, and presents one masked request at a time to the CPU.
// Latency: raw rise -> pending after SYNC_STAGES edges -> irq one edge later.
// Backpressure: non-nested; a new request is held off until ack then eoi.
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   reset      asynchronous active-high reset
//   irq_raw    raw source levels, may be asynchronous to clk
//   mask_we    one-cycle write strobe for the mask register
//   mask_data  new mask value (1 = source disabled)
//   ack        CPU interrupt-entry pulse
//   eoi        CPU end-of-interrupt pulse
//   irq        request to CPU
//   irq_id     index of the requesting / in-service source
//   pending    per-source pending bits
//   mask       current mask register
//   overrun    sticky per-source lost-edge flags
module interrupt_controller #(
  parameter int N_SRC       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_raw,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_data,
  input  logic             ack,
  input  logic             eoi,
  output logic             irq,
  output logic [1:0]       irq_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask,
  output logic [N_SRC-1:0] overrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             irq_q, irq_d;
  logic [1:0]       irq_id_q, irq_id_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] overrun_q, overrun_d;
  logic [N_SRC-1:0] mask_q, mask_d;

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] prev_q;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr;
  logic [1:0]       winner;

  // ---------------------------------------------------------------------------
  // Input synchronisers plus one history flop for edge detection
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= irq_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign eligible = pending_q & ~mask_q;

  // ---------------------------------------------------------------------------
  // Fixed priority: lowest index wins (scan high to low so the last hit sticks)
  // ---------------------------------------------------------------------------
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = 2'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    clr      = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Uses the registered mask, so a same-cycle mask write is not seen yet.
        if (|eligible) begin
          irq_id_d = winner;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        // irq_id stays frozen here; masking or new edges do not retarget it.
        if (ack) begin
          for (int i = 0; i < N_SRC; i++) begin
            clr[i] = (irq_id_q == 2'(i));
          end
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    irq_d = (state_d == ST_REQ);
  end

  // ---------------------------------------------------------------------------
  // Pending / overrun / mask next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // A fresh edge on the source being acknowledged re-arms pending (set wins)
    // but is not an overrun, since the old occurrence is being consumed.
    pending_d = (pending_q & ~clr) | rise;
    overrun_d = (overrun_q & ~clr) | (rise & pending_q & ~clr);
    mask_d    = mask_we ? mask_data : mask_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      mask_q    <= '1;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      mask_q    <= mask_d;
    end
  end

  assign irq     = irq_q;
  assign irq_id  = irq_id_q;
  assign pending = pending_q;
  assign mask    = mask_q;
  assign overrun = overrun_q;

  // Registered irq must always agree with the FSM, and the ID must name a source.
  a_irq_matches_state: assert property (@(posedge clk) disable iff (reset)
    irq_q == (state_q == ST_REQ));
  a_id_in_range: assert property (@(posedge clk) disable iff (reset)
    int'(irq_id_q) < N_SRC);

endmodule

// File: tb/tb_interrupt_controller.sv
`timescale 1ns/1ps
module tb_interrupt_controller;
  localparam int N = 3;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_raw;
  logic         mask_we;
  logic [N-1:0] mask_data;
  logic         ack;
  logic         eoi;
  logic         irq;
  logic [1:0]   irq_id;
  logic [N-1:0] pending;
  logic [N-1:0] mask;
  logic [N-1:0] overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  interrupt_controller #(.N_SRC(N), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_raw   (irq_raw),
    .mask_we   (mask_we),
    .mask_data (mask_data),
    .ack       (ack),
    .eoi       (eoi),
    .irq       (irq),
    .irq_id    (irq_id),
    .pending   (pending),
    .mask      (mask),
    .overrun   (overrun)
  );

  // ---------------------------------------------------------------------------
  // Reference model: a raw sample reaches the edge detector S edges after it
  // is taken; the rest follows the pending/mask/handshake rules directly.
  // ---------------------------------------------------------------------------
  localparam int M_IDLE = 0, M_REQ = 1, M_SVC = 2;
  logic [N-1:0] m_hist [S+1];   // m_hist[0] = most recent raw sample
  logic [N-1:0] m_pend, m_ovr, m_mask;
  int           m_state;
  logic [1:0]   m_id;

  task automatic model_reset();
    for (int s = 0; s <= S; s++) m_hist[s] = '0;
    m_pend  = '0;
    m_ovr   = '0;
    m_mask  = '1;
    m_state = M_IDLE;
    m_id    = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] edges, elig, taken;
    if (reset) begin
      model_reset();
      return;
    end
    edges = m_hist[S-1] & ~m_hist[S];
    elig  = m_pend & ~m_mask;
    taken = '0;
    if (m_state == M_IDLE) begin
      if (elig != 0) begin
        for (int i = 0; i < N; i++) begin
          if (elig[i]) begin
            m_id = 2'(i);
            break;
          end
        end
        m_state = M_REQ;
      end
    end else if (m_state == M_REQ) begin
      if (ack) begin
        taken   = {{(N-1){1'b0}}, 1'b1} << m_id;
        m_state = M_SVC;
      end
    end else if (eoi) begin
      m_state = M_IDLE;
    end
    m_ovr  = (m_ovr & ~taken) | (edges & m_pend & ~taken);
    m_pend = (m_pend & ~taken) | edges;
    if (mask_we) m_mask = mask_data;
    for (int s = S; s > 0; s--) m_hist[s] = m_hist[s-1];
    m_hist[0] = irq_raw;
  endtask

  // Advance one clock; inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wait_irq(input int max, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max && !ok; c++) begin
      step();
      ok = (irq === 1'b1);
    end
  endtask

  task automatic settle();
    irq_raw = '0;
    repeat (S + 2) step();
  endtask

  task automatic pulse_ack();
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; step(); eoi = 1'b0;
  endtask

  task automatic write_mask(input logic [N-1:0] v);
    mask_we = 1'b1; mask_data = v; step(); mask_we = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #2;
    n_checks++;
    if ({irq, irq_id, pending, mask, overrun} !== {1'b0, 2'd0, 3'b000, 3'b111, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_values: got irq=%b id=%0d pend=%b mask=%b ovr=%b, want 0/0/000/111/000",
               irq, irq_id, pending, mask, overrun);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    n_checks++;
    if ({irq, pending, mask} !== {1'b0, 3'b000, 3'b111}) begin
      n_fail++;
      $display("FAIL after_reset_idle: got irq=%b pend=%b mask=%b, want 0/000/111", irq, pending, mask);
    end
  endtask

  task automatic test_single();
    write_mask(3'b000);
    n_checks++;
    if (mask !== 3'b000) begin
      n_fail++; $display("FAIL mask_write: got %b want 000", mask);
    end
    irq_raw = 3'b010;
    step(); step();
    n_checks++;
    if (pending !== 3'b000) begin
      n_fail++; $display("FAIL single_pend_early: got %b want 000", pending);
    end
    step();
    n_checks++;
    if ({pending, irq} !== {3'b010, 1'b0}) begin
      n_fail++; $display("FAIL single_pend: got pend=%b irq=%b want 010/0", pending, irq);
    end
    irq_raw = 3'b000;
    step();
    n_checks++;
    if ({irq, irq_id} !== {1'b1, 2'd1}) begin
      n_fail++; $display("FAIL single_irq: got irq=%b id=%0d want 1/1", irq, irq_id);
    end
    pulse_ack();
    n_checks++;
    if ({irq, pending, overrun} !== {1'b0, 3'b000, 3'b000}) begin
      n_fail++; $display("FAIL single_ack: got irq=%b pend=%b ovr=%b want 0/000/000", irq, pending, overrun);
    end
    pulse_eoi();
    step();
    n_checks++;
    if ({irq, irq_id} !== {1'b0, 2'd1}) begin
      n_fail++; $display("FAIL single_eoi: got irq=%b id=%0d want 0/1", irq, irq_id);
    end
  endtask

  task automatic test_priority();
    bit ok;
    irq_raw = 3'b111;
    wait_irq(8, ok);
    irq_raw = 3'b000;
    n_checks++;
    if (!ok || irq_id !== 2'd0 || pending !== 3'b111) begin
      n_fail++; $display("FAIL prio_first: got ok=%b id=%0d pend=%b want 1/0/111", ok, irq_id, pending);
    end
    pulse_ack();
    n_checks++;
    if ({irq, pending} !== {1'b0, 3'b110}) begin
      n_fail++; $display("FAIL prio_ack0: got irq=%b pend=%b want 0/110", irq, pending);
    end
    pulse_eoi();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL prio_eoi_gap: got irq=%b want 0", irq);
    end
    step();
    n_checks++;
    if ({irq, irq_id} !== {1'b1, 2'd1}) begin
      n_fail++; $display("FAIL prio_second: got irq=%b id=%0d want 1/1", irq, irq_id);
    end
    pulse_ack();
    pulse_eoi();
    step();
    n_checks++;
    if ({irq, irq_id, pending} !== {1'b1, 2'd2, 3'b100}) begin
      n_fail++; $display("FAIL prio_third: got irq=%b id=%0d pend=%b want 1/2/100", irq, irq_id, pending);
    end
    pulse_ack();
    pulse_eoi();
    settle();
  endtask

  task automatic test_masking();
    write_mask(3'b001);
    irq_raw = 3'b001;
    repeat (4) step();
    n_checks++;
    if ({pending, irq} !== {3'b001, 1'b0}) begin
      n_fail++; $display("FAIL mask_blocks: got pend=%b irq=%b want 001/0", pending, irq);
    end
    write_mask(3'b000);
    n_checks++;
    if ({irq, mask} !== {1'b0, 3'b000}) begin
      n_fail++; $display("FAIL mask_old_used: got irq=%b mask=%b want 0/000", irq, mask);
    end
    step();
    n_checks++;
    if ({irq, irq_id} !== {1'b1, 2'd0}) begin
      n_fail++; $display("FAIL mask_release: got irq=%b id=%0d want 1/0", irq, irq_id);
    end
    pulse_ack();
    pulse_eoi();
    settle();
  endtask

  task automatic test_overrun();
    write_mask(3'b100);
    irq_raw = 3'b100; repeat (3) step();
    irq_raw = 3'b000; repeat (3) step();
    irq_raw = 3'b100; repeat (3) step();
    n_checks++;
    if ({pending, overrun, irq} !== {3'b100, 3'b100, 1'b0}) begin
      n_fail++; $display("FAIL overrun_set: got pend=%b ovr=%b irq=%b want 100/100/0", pending, overrun, irq);
    end
    irq_raw = 3'b000;
    write_mask(3'b000);
    step();
    n_checks++;
    if ({irq, irq_id} !== {1'b1, 2'd2}) begin
      n_fail++; $display("FAIL overrun_req: got irq=%b id=%0d want 1/2", irq, irq_id);
    end
    repeat (2) step();
    // Third edge lands on the pending register at the same edge as ack.
    irq_raw = 3'b100;
    step(); step();
    pulse_ack();
    n_checks++;
    if ({pending, overrun, irq} !== {3'b100, 3'b000, 1'b0}) begin
      n_fail++; $display("FAIL set_wins: got pend=%b ovr=%b irq=%b want 100/000/0", pending, overrun, irq);
    end
    pulse_eoi();
    step();
    n_checks++;
    if ({irq, irq_id} !== {1'b1, 2'd2}) begin
      n_fail++; $display("FAIL set_wins_rereq: got irq=%b id=%0d want 1/2", irq, irq_id);
    end
    pulse_ack();
    pulse_eoi();
    settle();
  endtask

  task automatic test_reset_mid();
    bit ok;
    irq_raw = 3'b011;
    wait_irq(8, ok);
    n_checks++;
    if (!ok || irq_id !== 2'd0 || pending !== 3'b011) begin
      n_fail++; $display("FAIL mid_setup: got ok=%b id=%0d pend=%b want 1/0/011", ok, irq_id, pending);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({irq, irq_id, pending, mask, overrun} !== {1'b0, 2'd0, 3'b000, 3'b111, 3'b000}) begin
      n_fail++;
      $display("FAIL mid_reset_async: got irq=%b id=%0d pend=%b mask=%b ovr=%b want 0/0/000/111/000",
               irq, irq_id, pending, mask, overrun);
    end
    irq_raw = 3'b000;
    repeat (3) step();
    reset = 1'b0;
    step();
    n_checks++;
    if ({irq, pending, mask} !== {1'b0, 3'b000, 3'b111}) begin
      n_fail++; $display("FAIL mid_reset_release: got irq=%b pend=%b mask=%b want 0/000/111", irq, pending, mask);
    end
  endtask

  task automatic test_spurious();
    bit ok;
    pulse_ack();
    n_checks++;
    if ({irq, pending, mask} !== {1'b0, 3'b000, 3'b111}) begin
      n_fail++; $display("FAIL ack_in_idle: got irq=%b pend=%b mask=%b want 0/000/111", irq, pending, mask);
    end
    write_mask(3'b000);
    irq_raw = 3'b100;
    wait_irq(8, ok);
    irq_raw = 3'b000;
    pulse_eoi();
    n_checks++;
    if (!ok || {irq, irq_id, pending} !== {1'b1, 2'd2, 3'b100}) begin
      n_fail++; $display("FAIL eoi_in_req: got ok=%b irq=%b id=%0d pend=%b want 1/1/2/100", ok, irq, irq_id, pending);
    end
    pulse_ack();
    n_checks++;
    if ({irq, pending} !== {1'b0, 3'b000}) begin
      n_fail++; $display("FAIL spurious_ack_ok: got irq=%b pend=%b want 0/000", irq, pending);
    end
    pulse_ack();
    pulse_eoi();
    settle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) irq_raw[b] = ~irq_raw[b];
      end
      mask_we   = ($urandom_range(0, 15) == 0);
      mask_data = N'($urandom & $urandom);
      ack       = (m_state == M_REQ) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      eoi       = ($urandom_range(0, 3) == 0);
      step();
      n_checks++;
      if ({irq, irq_id} !== {(m_state == M_REQ), m_id}) begin
        n_fail++; $display("FAIL rand_irq c=%0d: got irq=%b id=%0d want %b/%0d", c, irq, irq_id, m_state == M_REQ, m_id);
      end
      n_checks++;
      if ({pending, overrun} !== {m_pend, m_ovr}) begin
        n_fail++; $display("FAIL rand_pend c=%0d: got pend=%b ovr=%b want %b/%b", c, pending, overrun, m_pend, m_ovr);
      end
      n_checks++;
      if (mask !== m_mask) begin
        n_fail++; $display("FAIL rand_mask c=%0d: got %b want %b", c, mask, m_mask);
      end
    end
    ack = 1'b0; eoi = 1'b0; mask_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_raw = '0; mask_we = 1'b0; mask_data = '0; ack = 1'b0; eoi = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_overrun();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Sits between the interrupt sources (the two external lines and the timer output) and the CPU interrupt input. It synchronises each raw source and detects rising edges into per-source pending bits. It applies a CPU-writable mask and presents one request at a time with a frozen source ID. The CPU handshakes with an acknowledge pulse and an end-of-interrupt pulse, so servicing is non-nested.

## Interface
Parameters:
- N_SRC, 3, number of sources (1..4); bit 0 is the timer and has the highest priority, bit N_SRC-1 has the lowest.
- SYNC_STAGES, 2, synchroniser flops per raw source (≥2).

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- irq_raw  in  N_SRC  raw source levels; may be asynchronous to clk.
- mask_we  in  1  one-cycle write strobe for the mask register.
- mask_data  in  N_SRC  new mask value (1 = source disabled).
- ack  in  1  one-cycle pulse from CPU on interrupt entry.
- eoi  in  1  one-cycle pulse from CPU on return from interrupt.
- irq  out  1  request to CPU.
- irq_id  out  2  index of the requesting source; valid while irq=1 or in service.
- pending  out  N_SRC  pending bits (readable by CPU).
- mask  out  N_SRC  current mask register.
- overrun  out  N_SRC  sticky per-source flag for an edge lost while that source was already pending.

## Operation
**Reset values**
- irq=0, irq_id=0, pending=0, mask=all ones, overrun=0.
- Synchroniser and edge-history flops are 0.
- FSM is in IDLE.

**Input path**
- Each irq_raw bit passes through SYNC_STAGES flops.
- A rising edge is sync_out & ~sync_prev.
- A rising edge sets pending[i] regardless of the mask; the mask gates requests only.
- An edge on a source whose pending bit is already 1 sets overrun[i].

**Mask**
- On mask_we, mask <= mask_data at that clock edge.

**Eligibility and priority**
- eligible = pending & ~mask.
- The winner is the lowest set index of eligible.

**FSM (IDLE, REQ, SERVICE)**
- IDLE: if eligible≠0, latch the winner into irq_id and go to REQ. Otherwise stay.
- REQ: irq=1 and irq_id is frozen.
  - ack: clear pending[irq_id] and overrun[irq_id], go to SERVICE, irq drops to 0 on the same edge.
  - Masking the source while in REQ does not withdraw the request.
- SERVICE: irq=0 and irq_id is held. On eoi, go to IDLE.
- An ack outside REQ is ignored. An eoi outside SERVICE is ignored.

**Simultaneous events**
- A new edge on source i in the same cycle that ack clears pending[i]: pending[i] ends at 1 (set wins) and overrun[i] ends at 0.
- An edge on a lower-priority source while the FSM is in REQ does not change irq_id.
- mask_we together with the IDLE evaluation in the same cycle: the evaluation uses the old mask.

**Reset mid-operation**
- Reset asserted in any state returns every output and register to its reset value asynchronously.
- After reset deasserts, the first evaluation happens on the next clock edge.

## Timing
- Latency: raw rise first sampled at edge k → pending[i] visible after edge k+SYNC_STAGES → irq=1 after edge k+SYNC_STAGES+1. With the default SYNC_STAGES=2, that is 3 edges.
- irq goes high one edge after IDLE sees eligible≠0. It falls on the ack edge.
- SERVICE to IDLE takes one edge after eoi. A further pending source raises irq on the next edge after that (minimum 2 edges from eoi).
- Raw pulses must be high for at least 2 clk periods to be guaranteed captured. Shorter pulses may be missed.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Test plan
- **Reset, enable and single request.** Reset, then mask_we with mask_data=3'b000, then irq_raw=3'b010 held for 3 cycles → pending=3'b010 after 2 edges; irq=1 with irq_id=1 one edge later; ack → irq=0, pending=0; eoi → IDLE.
- **Priority.** Mask 0; irq_raw rises 3'b110 and 3'b001 in the same cycle → irq_id=0 first. After ack+eoi, irq_id=1. After the next ack+eoi, irq_id=2.
- **Masking.** mask=3'b001, timer edge → pending[0]=1 but irq stays 0. Write mask=0 → irq=1 with irq_id=0 one edge later.
- **Overrun and set-wins.** Two edges on source 2 before ack → overrun[2]=1. A third edge in the same cycle as ack → pending[2]=1 and overrun[2]=0 afterwards.
- **Reset mid-operation.** Assert reset while in REQ with pending=3'b011 → irq, pending and overrun become 0 and mask becomes 3'b111 without waiting for a clk edge.
- **Spurious handshakes.** ack in IDLE and eoi in REQ → no change to state, pending or outputs.
